pea_loader: RTL

PEA_LOADER -- requirements
Module: pea_loader

---
 rtl/pea_loader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pea_loader.sv
// PE-array loader: streams source words round-robin into NUM_ROW row buffers (word k -> row k%NUM_ROW, addr k/NUM_ROW).
// Latency: one cycle from s_valid&s_ready to the wr_en strobe; load_done coincides with the final write.
// Backpressure: s_ready drops combinationally while the target row is busy/full or the RAMs are in reset. Optional stall counter via PEA_LOADER_STALL_CNT_EN.
module pea_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_ROW     = 7,
    parameter int BUFFER_SIZE = 512,
    parameter int AW          = $clog2(BUFFER_SIZE),
    parameter int LW          = $clog2(NUM_ROW*BUFFER_SIZE)+1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_ifmap,
    input  logic                  load_fltr,
    input  logic                  load_psum,
    input  logic [LW-1:0]         ifmap_len,
    input  logic [LW-1:0]         fltr_len,
    input  logic [LW-1:0]         psum_len,
    input  logic                  ram_rst_busy,
    input  logic [NUM_ROW-1:0]    ram_load_busy,
    input  logic [NUM_ROW-1:0]    full,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [NUM_ROW-1:0]    wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [AW-1:0]         wr_addr,
    output logic [1:0]            wr_sel,
    output logic                  load_done,
`ifdef PEA_LOADER_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  cmd_err
);

    localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(NUM_ROW*BUFFER_SIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    typ;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cnt;
    logic [RW-1:0] row;
    logic [AW-1:0] addr;

    logic [1:0]    req_type;
    logic [LW-1:0] req_len;
    logic          req_any;
    logic          multi_req;
    logic          start;
    logic          len_bad;
    logic          go_load;
    logic          typ_req;
    logic          row_stall;
    logic          xfer;
    logic          last;

    always_comb begin
        req_type = 2'd2;
        req_len  = psum_len;
        if (load_ifmap) begin
            req_type = 2'd0;
            req_len  = ifmap_len;
        end else if (load_fltr) begin
            req_type = 2'd1;
            req_len  = fltr_len;
        end
    end

    always_comb begin
        case (typ)
            2'd0:    typ_req = load_ifmap;
            2'd1:    typ_req = load_fltr;
            default: typ_req = load_psum;
        endcase
    end

    assign req_any   = load_ifmap | load_fltr | load_psum;
    assign multi_req = (load_ifmap & load_fltr) | (load_ifmap & load_psum) | (load_fltr & load_psum);
    assign start     = (state == ST_IDLE) & ~ram_rst_busy & req_any;
    assign len_bad   = (req_len == '0) | (req_len > MAX_LEN);
    assign go_load   = start & ~len_bad;

    assign row_stall = ram_load_busy[row] | full[row];
    assign s_ready   = (state == ST_LOAD) & ~ram_rst_busy & ~row_stall;
    assign xfer      = s_valid & s_ready;
    assign last      = ((cnt + LW'(1)) == len_q);
    assign load_done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            typ     <= 2'd0;
            len_q   <= '0;
            cnt     <= '0;
            row     <= '0;
            addr    <= '0;
            wr_en   <= '0;
            wr_data <= '0;
            wr_addr <= '0;
            wr_sel  <= 2'd0;
            cmd_err <= 1'b0;
        end else begin
            wr_en <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        typ   <= req_type;
                        len_q <= req_len;
                        cnt   <= '0;
                        row   <= '0;
                        addr  <= '0;
                        if (multi_req || (req_len > MAX_LEN))
                            cmd_err <= 1'b1;
                        state <= len_bad ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wr_en   <= NUM_ROW'(1) << row;
                        wr_data <= s_data;
                        wr_addr <= addr;
                        wr_sel  <= typ;
                        cnt     <= cnt + LW'(1);
                        if (row == RW'(NUM_ROW-1)) begin
                            row  <= '0;
                            addr <= addr + AW'(1);
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                    // RAM reset wins over everything; a dropped request is a protocol error.
                    if (ram_rst_busy) begin
                        state <= ST_IDLE;
                    end else if (!typ_req) begin
                        state   <= ST_IDLE;
                        cmd_err <= 1'b1;
                    end else if (xfer && last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PEA_LOADER_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= 16'd0;
        end else if (go_load) begin
            stall_cnt <= 16'd0;
        end else if ((state == ST_LOAD) && s_valid && !s_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
